// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 256-bit lines.
// Optional hit/miss/writeback counters when DCACHE_PERF_EN is defined.
module dcache_direct_mapped #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]  perf_hits,
    output logic [31:0]  perf_misses,
    output logic [31:0]  perf_writebacks
`endif
);

    localparam int TAG_W    = 32 - S_INDEX - S_OFFSET;
    localparam int NUM_SETS = 1 << S_INDEX;

    typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;

    state_t state_q;

    logic [TAG_W-1:0]   addr_tag;
    logic [S_INDEX-1:0] addr_index;
    logic [2:0]         addr_word;
    logic [1:0]         addr_lsb_unused;

    assign addr_tag        = mem_address[31 -: TAG_W];
    assign addr_index      = mem_address[S_OFFSET +: S_INDEX];
    assign addr_word       = mem_address[4:2];
    assign addr_lsb_unused = mem_address[1:0];

    logic [255:0]       data_mem [NUM_SETS];
    logic [TAG_W-1:0]   tag_mem  [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;

    logic [255:0]     line_rd;
    logic [TAG_W-1:0] tag_rd;
    logic [31:0]      word_rd;
    logic [31:0]      word_merged;
    logic [255:0]     line_merged;
    logic             hit;

    assign line_rd = data_mem[addr_index];
    assign tag_rd  = tag_mem[addr_index];
    assign word_rd = line_rd[{addr_word, 5'b0} +: 32];
    assign hit     = valid_q[addr_index] && (tag_rd == addr_tag);

    // Byte-lane merge of the store data into the addressed word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign word_merged[gi*8 +: 8] = mem_byte_enable[gi] ? mem_wdata[gi*8 +: 8]
                                                                : word_rd[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        line_merged = line_rd;
        line_merged[{addr_word, 5'b0} +: 32] = word_merged;
    end

    logic [31:0]  mem_rdata_q;
    logic         mem_resp_q;
    logic         pmem_read_q;
    logic         pmem_write_q;
    logic [31:0]  pmem_address_q;
    logic [255:0] pmem_wdata_q;

    logic fill_done;
    logic hit_write;

    // CHECK responds on its second cycle; mem_resp_q marks that response cycle.
    assign fill_done = (state_q == FILL) && pmem_resp;
    assign hit_write = (state_q == CHECK) && !mem_resp_q && hit && mem_write
                       && (mem_byte_enable != 4'b0000);

    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_mem[addr_index] <= pmem_rdata;
            tag_mem[addr_index]  <= addr_tag;
        end else if (hit_write) begin
            data_mem[addr_index] <= line_merged;
        end
    end

`ifdef DCACHE_PERF_EN
    logic [31:0] perf_hits_q, perf_misses_q, perf_writebacks_q;
    assign perf_hits       = perf_hits_q;
    assign perf_misses     = perf_misses_q;
    assign perf_writebacks = perf_writebacks_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            valid_q        <= '0;
            dirty_q        <= '0;
            mem_rdata_q    <= '0;
            mem_resp_q     <= 1'b0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
`ifdef DCACHE_PERF_EN
            perf_hits_q       <= '0;
            perf_misses_q     <= '0;
            perf_writebacks_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (mem_resp_q) begin
                        mem_resp_q <= 1'b0;
                        state_q    <= IDLE;
                    end else if (hit) begin
                        mem_resp_q <= 1'b1;
                        if (mem_write) begin
                            if (mem_byte_enable != 4'b0000) begin
                                dirty_q[addr_index] <= 1'b1;
                            end
                        end else begin
                            mem_rdata_q <= word_rd;
                        end
`ifdef DCACHE_PERF_EN
                        if (perf_hits_q != '1) perf_hits_q <= perf_hits_q + 32'd1;
`endif
                    end else begin
`ifdef DCACHE_PERF_EN
                        if (perf_misses_q != '1) perf_misses_q <= perf_misses_q + 32'd1;
`endif
                        if (dirty_q[addr_index]) begin
                            pmem_write_q   <= 1'b1;
                            pmem_address_q <= {tag_rd, addr_index, {S_OFFSET{1'b0}}};
                            pmem_wdata_q   <= line_rd;
                            state_q        <= WB;
                        end else begin
                            pmem_read_q    <= 1'b1;
                            pmem_address_q <= {mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
                            state_q        <= FILL;
                        end
                    end
                end
                WB: begin
                    if (pmem_resp) begin
                        pmem_write_q   <= 1'b0;
                        pmem_read_q    <= 1'b1;
                        pmem_address_q <= {mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
                        state_q        <= FILL;
`ifdef DCACHE_PERF_EN
                        if (perf_writebacks_q != '1) perf_writebacks_q <= perf_writebacks_q + 32'd1;
`endif
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        pmem_read_q         <= 1'b0;
                        valid_q[addr_index] <= 1'b1;
                        dirty_q[addr_index] <= 1'b0;
                        state_q             <= CHECK;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_rdata    = mem_rdata_q;
    assign mem_resp     = mem_resp_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped: small line-memory model plus hand-computed expectations.
module tb_dcache_direct_mapped;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [31:0]  mem_wdata = '0;
    logic [3:0]   mem_byte_enable = '0;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
`ifdef DCACHE_PERF_EN
    logic [31:0]  perf_hits, perf_misses, perf_writebacks;
`endif

    dcache_direct_mapped dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
`ifdef DCACHE_PERF_EN
        ,
        .perf_hits       (perf_hits),
        .perf_misses     (perf_misses),
        .perf_writebacks (perf_writebacks)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Line memory: untouched lines hold word address + 0x1000_0000 per word,
    // except word0 of line 0x40 which is 0xDEADBEEF.
    logic [255:0] mem [logic [31:0]];
    int           rd_cnt = 0;
    int           wr_cnt = 0;
    int           lat = 0;
    int           excl_bad = 0;
    logic [31:0]  last_rd_addr = '0;
    logic [31:0]  last_wr_addr = '0;
    logic [255:0] last_wr_data = '0;

    function automatic logic [255:0] default_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'h1000_0000 + a + 32'(w * 4);
        if (a == 32'h40) l[31:0] = 32'hDEAD_BEEF;
        return l;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            pmem_resp = 1'b0;
            lat = 0;
        end else if (pmem_resp) begin
            pmem_resp = 1'b0;
        end else if (pmem_read || pmem_write) begin
            if (lat == 2) begin
                lat = 0;
                pmem_resp = 1'b1;
                if (pmem_write) begin
                    mem[pmem_address] = pmem_wdata;
                    wr_cnt++;
                    last_wr_addr = pmem_address;
                    last_wr_data = pmem_wdata;
                end else begin
                    pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : default_line(pmem_address);
                    rd_cnt++;
                    last_rd_addr = pmem_address;
                end
            end else begin
                lat++;
            end
        end
    end

    always @(posedge clk) begin
        if (pmem_read && pmem_write) excl_bad++;
    end

    task automatic cpu_op(input string name, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rdata, output int cyc);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_resp) break;
        end
        check_eq({name, "_resp"}, mem_resp, 1'b1);
        rdata = mem_rdata;
        mem_read = 1'b0; mem_write = 1'b0;
        $display("op %-10s rd=%0b wr=%0b addr=%08h wdata=%08h mbe=%04b -> rdata=%08h cycles=%0d",
                 name, rd, wr, a, wd, be, rdata, cyc);
        @(posedge clk); #1;
        check_eq({name, "_pulse"}, mem_resp, 1'b0);
        check_eq({name, "_hold"}, mem_rdata, rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        int cyc, rd0, wr0, k;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_resp", mem_resp, 1'b0);
        check_eq("rst_pread", pmem_read, 1'b0);
        check_eq("rst_pwrite", pmem_write, 1'b0);
        check_eq("rst_paddr", pmem_address, 32'h0);
        check_eq("rst_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        rd0 = rd_cnt; wr0 = wr_cnt;
        cpu_op("cold_40", 1, 0, 32'h40, 32'h0, 4'h0, rdata, cyc);
        check_eq("cold_40_data", rdata, 32'hDEAD_BEEF);
        check_eq("cold_40_nrd", rd_cnt - rd0, 1);
        check_eq("cold_40_addr", last_rd_addr, 32'h40);
        check_eq("cold_40_nwr", wr_cnt - wr0, 0);

        rd0 = rd_cnt; wr0 = wr_cnt;
        cpu_op("hit_44", 1, 0, 32'h44, 32'h0, 4'h0, rdata, cyc);
        check_eq("hit_44_data", rdata, 32'h1000_0044);
        check_eq("hit_44_lat", cyc, 2);
        check_eq("hit_44_npmem", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

        rd0 = rd_cnt; wr0 = wr_cnt;
        cpu_op("wr_40", 0, 1, 32'h40, 32'h0000_AB00, 4'b0010, rdata, cyc);
        check_eq("wr_40_lat", cyc, 2);
        check_eq("wr_40_npmem", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

        cpu_op("rd_40", 1, 0, 32'h40, 32'h0, 4'h0, rdata, cyc);
        check_eq("rd_40_data", rdata, 32'hDEAD_ABEF);

        // Evict the dirty line, then pull reset while the fill is outstanding.
        wr0 = wr_cnt;
        @(posedge clk); #1;
        mem_read = 1'b1; mem_address = 32'h140;
        k = 0;
        while (k < 200) begin
            @(posedge clk); #1;
            k++;
            if (pmem_read && pmem_address == 32'h140) break;
        end
        check_eq("fill_140_req", pmem_read, 1'b1);
        check_eq("fill_140_addr", pmem_address, 32'h140);
        check_eq("wb_40_count", wr_cnt - wr0, 1);
        check_eq("wb_40_addr", last_wr_addr, 32'h40);
        check_eq("wb_40_word0", last_wr_data[31:0], 32'hDEAD_ABEF);
        check_eq("wb_40_word7", last_wr_data[255:224], 32'h1000_005C);
`ifdef DCACHE_PERF_EN
        check_eq("perf_hits", perf_hits, 4);
        check_eq("perf_misses", perf_misses, 2);
        check_eq("perf_wbs", perf_writebacks, 1);
`endif
        #1 rst = 1'b0;
        #1;
        $display("op reset_mid_fill pread=%0b pwrite=%0b paddr=%08h", pmem_read, pmem_write, pmem_address);
        check_eq("arst_pread", pmem_read, 1'b0);
        check_eq("arst_pwrite", pmem_write, 1'b0);
        check_eq("arst_paddr", pmem_address, 32'h0);
        check_eq("arst_rdata", mem_rdata, 32'h0);
`ifdef DCACHE_PERF_EN
        check_eq("arst_perf_hits", perf_hits, 0);
`endif
        mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        rd0 = rd_cnt;
        cpu_op("reread_40", 1, 0, 32'h40, 32'h0, 4'h0, rdata, cyc);
        check_eq("reread_40_nrd", rd_cnt - rd0, 1);
        check_eq("reread_40_data", rdata, 32'hDEAD_ABEF);

        cpu_op("wr0_48", 0, 1, 32'h48, 32'hFFFF_FFFF, 4'b0000, rdata, cyc);
        check_eq("wr0_48_lat", cyc, 2);
        cpu_op("rd_48", 1, 0, 32'h48, 32'h0, 4'h0, rdata, cyc);
        check_eq("rd_48_data", rdata, 32'h1000_0048);

        rd0 = rd_cnt; wr0 = wr_cnt;
        cpu_op("clean_140", 1, 0, 32'h140, 32'h0, 4'h0, rdata, cyc);
        check_eq("clean_140_nwr", wr_cnt - wr0, 0);
        check_eq("clean_140_nrd", rd_cnt - rd0, 1);
        check_eq("clean_140_data", rdata, 32'h1000_0140);

        cpu_op("rw_14c", 1, 1, 32'h14C, 32'h1234_5678, 4'b1111, rdata, cyc);
        cpu_op("rd_14c", 1, 0, 32'h14C, 32'h0, 4'h0, rdata, cyc);
        check_eq("rd_14c_data", rdata, 32'h1234_5678);

        wr0 = wr_cnt;
        cpu_op("evict_140", 1, 0, 32'h40, 32'h0, 4'h0, rdata, cyc);
        check_eq("evict_140_nwr", wr_cnt - wr0, 1);
        check_eq("evict_140_addr", last_wr_addr, 32'h140);
        check_eq("evict_140_word3", last_wr_data[127:96], 32'h1234_5678);
        check_eq("evict_140_data", rdata, 32'hDEAD_ABEF);

        check_eq("pmem_exclusive", excl_bad, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
